// File: rtl/pkt_rcv.sv
// Receive end of the 3-wire packet link: synchronises sclk/load/sdi into clk,
// shifts PKT_W bits MSB-first while load is low and reports each frame on load rising.
module pkt_rcv #(
   parameter int PKT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclk,
   input  logic             load,
   input  logic             sdi,
   output logic [PKT_W-1:0] pkt,
   output logic             pvld,
   output logic             ferr,
   output logic             busy
);

   // state | meaning
   // ARM   | after reset, wait for load high so a half-seen frame is never accepted
   // IDLE  | between frames, waiting for load to fall
   // SHIFT | frame open, shifting sdi on each sclk rise
   typedef enum logic [1:0] {ARM, IDLE, SHIFT} state_t;

   localparam int CNT_W = $clog2(PKT_W + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PKT_W);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(PKT_W + 1);

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
   logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic                   load_prev_q, load_prev_d;
   logic [PKT_W-1:0]       shreg_q, shreg_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [PKT_W-1:0]       pkt_q, pkt_d;
   logic                   pvld_q, pvld_d;
   logic                   ferr_q, ferr_d;
   logic                   busy_q, busy_d;

   logic sclk_s, load_s, sdi_s;
   logic sclk_rise, load_rise, load_fall;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign load_s    = load_sync_q[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign load_rise = load_s & ~load_prev_q;
   assign load_fall = ~load_s & load_prev_q;

   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      load_sync_d = {load_sync_q[SYNC_STAGES-2:0], load};
      sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      sclk_prev_d = sclk_s;
      load_prev_d = load_s;
      state_d     = state_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      pkt_d       = pkt_q;
      pvld_d      = 1'b0;
      ferr_d      = 1'b0;

      case (state_q)
         ARM: begin
            if (load_s) state_d = IDLE;
         end
         IDLE: begin
            if (load_fall) begin
               state_d = SHIFT;
               cnt_d   = '0;
               shreg_d = '0;
            end
         end
         SHIFT: begin
            // frame close takes priority over a coincident sclk edge
            if (load_rise) begin
               state_d = IDLE;
               if (cnt_q == CNT_FULL) begin
                  pkt_d  = shreg_q;
                  pvld_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else if (sclk_rise) begin
               shreg_d = {shreg_q[PKT_W-2:0], sdi_s};
               if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ARM;
      endcase

      busy_d = (state_d == SHIFT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ARM;
         sclk_sync_q <= '0;
         load_sync_q <= '0;
         sdi_sync_q  <= '0;
         sclk_prev_q <= 1'b0;
         load_prev_q <= 1'b0;
         shreg_q     <= '0;
         cnt_q       <= '0;
         pkt_q       <= '0;
         pvld_q      <= 1'b0;
         ferr_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sclk_sync_q <= sclk_sync_d;
         load_sync_q <= load_sync_d;
         sdi_sync_q  <= sdi_sync_d;
         sclk_prev_q <= sclk_prev_d;
         load_prev_q <= load_prev_d;
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         pkt_q       <= pkt_d;
         pvld_q      <= pvld_d;
         ferr_q      <= ferr_d;
         busy_q      <= busy_d;
      end
   end

   assign pkt  = pkt_q;
   assign pvld = pvld_q;
   assign ferr = ferr_q;
   assign busy = busy_q;

endmodule
